// File: rtl/bm_pkg.sv
// Shared constants for the bitonic merge network: sort-direction encodings and default element width.
package bm_pkg;

    localparam logic DIR_ASC       = 1'b1;
    localparam logic DIR_DESC      = 1'b0;
    localparam int   BM_DATA_WIDTH = 32;

endpackage

// File: rtl/bm_cas.sv
// Combinational compare-and-swap cell. Compare is unsigned unless BM4_SIGNED_EN is defined,
// in which case elements are treated as two's-complement.
module bm_cas
    import bm_pkg::*;
#(
    parameter int DATA_WIDTH = BM_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  dir,
    output logic [DATA_WIDTH-1:0] first,
    output logic [DATA_WIDTH-1:0] second
);

    logic a_gt_b;
    logic b_gt_a;
    logic swap;

`ifdef BM4_SIGNED_EN
    assign a_gt_b = $signed(a) > $signed(b);
    assign b_gt_a = $signed(b) > $signed(a);
`else
    assign a_gt_b = a > b;
    assign b_gt_a = b > a;
`endif

    // Equal operands never swap, so ties pass straight through.
    assign swap = (dir == DIR_ASC) ? a_gt_b : b_gt_a;

    always_comb begin
        first  = a;
        second = b;
        if (swap) begin
            first  = b;
            second = a;
        end
    end

endmodule

// File: rtl/bitonic_merge4.sv
// Two-stage pipelined 4-element bitonic merger; direction travels with its sample.
// Optional build macro BM4_SIGNED_EN selects signed element compare.
module bitonic_merge4
    import bm_pkg::*;
#(
    parameter int DATA_WIDTH = BM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  direction,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    input  logic [DATA_WIDTH-1:0] in3,
    input  logic [DATA_WIDTH-1:0] in4,
    output logic [DATA_WIDTH-1:0] o1,
    output logic [DATA_WIDTH-1:0] o2,
    output logic [DATA_WIDTH-1:0] o3,
    output logic [DATA_WIDTH-1:0] o4
);

    logic [DATA_WIDTH-1:0] s1_d, s2_d, s3_d, s4_d;
    logic [DATA_WIDTH-1:0] s1_q, s2_q, s3_q, s4_q;
    logic                  dir_s1_q;
    logic [DATA_WIDTH-1:0] o1_d, o2_d, o3_d, o4_d;
    logic [DATA_WIDTH-1:0] o1_q, o2_q, o3_q, o4_q;

    // Stage 1: compare elements half the sequence apart.
    bm_cas #(.DATA_WIDTH(DATA_WIDTH)) u_cas_13 (
        .a(in1), .b(in3), .dir(direction), .first(s1_d), .second(s3_d)
    );
    bm_cas #(.DATA_WIDTH(DATA_WIDTH)) u_cas_24 (
        .a(in2), .b(in4), .dir(direction), .first(s2_d), .second(s4_d)
    );

    // Stage 2: adjacent pairs, using the direction captured with this sample.
    bm_cas #(.DATA_WIDTH(DATA_WIDTH)) u_cas_12 (
        .a(s1_q), .b(s2_q), .dir(dir_s1_q), .first(o1_d), .second(o2_d)
    );
    bm_cas #(.DATA_WIDTH(DATA_WIDTH)) u_cas_34 (
        .a(s3_q), .b(s4_q), .dir(dir_s1_q), .first(o3_d), .second(o4_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            s4_q     <= '0;
            dir_s1_q <= 1'b0;
            o1_q     <= '0;
            o2_q     <= '0;
            o3_q     <= '0;
            o4_q     <= '0;
        end else if (en) begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            s4_q     <= s4_d;
            dir_s1_q <= direction;
            o1_q     <= o1_d;
            o2_q     <= o2_d;
            o3_q     <= o3_d;
            o4_q     <= o4_d;
        end
    end

    assign o1 = o1_q;
    assign o2 = o2_q;
    assign o3 = o3_q;
    assign o4 = o4_q;

endmodule

// File: tb/tb_bitonic_merge4.sv
// Directed bench for bitonic_merge4: issued samples push expected results, a monitor pops and compares.
module tb_bitonic_merge4;

    logic        clk;
    logic        rst;
    logic        en;
    logic        direction;
    logic [31:0] in1, in2, in3, in4;
    logic [31:0] o1, o2, o3, o4;

    logic [127:0] exp_q[$];
    int           chk_cnt  = 0;
    int           pass_cnt = 0;

    // Bench-side occupancy model: marks edges where a tracked sample reaches the outputs.
    logic in_valid;
    logic v1;
    logic new_out;

    bitonic_merge4 #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .en(en), .direction(direction),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .o1(o1), .o2(o2), .o3(o3), .o4(o4)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1      <= 1'b0;
            new_out <= 1'b0;
        end else if (en) begin
            v1      <= in_valid;
            new_out <= v1;
        end else begin
            new_out <= 1'b0;
        end
    end

    function automatic logic [127:0] pk(input logic [31:0] a, b, c, d);
        return {a, b, c, d};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // Driver: presents one sample for one enabled edge and records its expected result.
    task automatic issue(input logic [31:0] a, b, c, d, input logic dir, input logic [127:0] exp);
        in1 = a; in2 = b; in3 = c; in4 = d;
        direction = dir;
        in_valid  = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst && new_out) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {o1, o2, o3, o4}, 128'h0);
                if ({o1, o2, o3, o4} === 128'h0) begin
                    pass_cnt--;
                    $display("FAIL unexpected_output: got output with empty queue, required none");
                end
            end else begin
                check("scoreboard", {o1, o2, o3, o4}, exp_q.pop_front());
            end
        end
    end

`ifdef BM4_SIGNED_EN
    localparam logic [127:0] EDGE_EXP = {32'hFFFF_FFFF, 32'd0, 32'd5, 32'd5};
`else
    localparam logic [127:0] EDGE_EXP = {32'd0, 32'd5, 32'd5, 32'hFFFF_FFFF};
`endif

    logic [127:0] snap;

    initial begin
        rst = 1'b0; en = 1'b1; direction = 1'b1; in_valid = 1'b0;
        in1 = 32'h1234; in2 = 32'hABCD; in3 = 32'h7; in4 = 32'h99;

        // Held in reset with en high and arbitrary inputs.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold", {o1, o2, o3, o4}, 128'h0);
        end

        rst = 1'b1;
        // Back-to-back samples with a direction change, then an edge-value sample.
        issue(32'd6, 32'd5, 32'd4, 32'd3, 1'b1, pk(32'd3, 32'd4, 32'd5, 32'd6));
        issue(32'd1, 32'd4, 32'd7, 32'd2, 1'b0, pk(32'd7, 32'd4, 32'd2, 32'd1));
        issue(32'hFFFF_FFFF, 32'd5, 32'd5, 32'd0, 1'b1, EDGE_EXP);
        issue(32'd2, 32'd9, 32'd9, 32'd2, 1'b0, pk(32'd9, 32'd9, 32'd2, 32'd2));
        repeat (3) @(negedge clk);

        // Enable stall with the sample sitting in stage 1.
        issue(32'd6, 32'd5, 32'd4, 32'd3, 1'b1, pk(32'd3, 32'd4, 32'd5, 32'd6));
        en = 1'b0;
        in1 = 32'd9; in2 = 32'd9; in3 = 32'd9; in4 = 32'd9;
        snap = {o1, o2, o3, o4};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_hold", {o1, o2, o3, o4}, snap);
        end
        en = 1'b1;
        repeat (3) @(negedge clk);

        // Reset mid-stream: outputs clear without waiting for a clock edge.
        issue(32'd1, 32'd4, 32'd7, 32'd2, 1'b0, pk(32'd7, 32'd4, 32'd2, 32'd1));
        #2 rst = 1'b0;
        #1 check("reset_async", {o1, o2, o3, o4}, 128'h0);
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_mid_hold", {o1, o2, o3, o4}, 128'h0);
        end

        // Recovery: one edge after release the outputs are still clear.
        rst = 1'b1;
        issue(32'd6, 32'd5, 32'd4, 32'd3, 1'b1, pk(32'd3, 32'd4, 32'd5, 32'd6));
        check("post_release_1edge", {o1, o2, o3, o4}, 128'h0);
        repeat (3) @(negedge clk);

        check("queue_drained", 128'(exp_q.size()), 128'h0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/bitonic_merge4.md
Name: bitonic_merge4

Overview:
- 4-input bitonic merger: a two-stage compare-and-swap network that turns a 4-element bitonic sequence into a fully sorted sequence.
- Sort direction is selectable per sample.
- Pipelined, one result per enabled clock.
- Used as the final merge stage of the 4-input bitonic sorter, and as a building block for larger merges.

Parameters:
- DATA_WIDTH, 32, bit width of each element (unsigned magnitude compare unless BM4_SIGNED_EN).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- en  input  1  pipeline advance enable; all registers hold when low.
- direction  input  1  1 = ascending (o1 smallest), 0 = descending (o1 largest).
- in1  input  DATA_WIDTH  element 0 of the bitonic sequence.
- in2  input  DATA_WIDTH  element 1.
- in3  input  DATA_WIDTH  element 2.
- in4  input  DATA_WIDTH  element 3.
- o1  output  DATA_WIDTH  sorted element 0 (registered).
- o2  output  DATA_WIDTH  sorted element 1 (registered).
- o3  output  DATA_WIDTH  sorted element 2 (registered).
- o4  output  DATA_WIDTH  sorted element 3 (registered).

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst low asynchronously clears all stage-1 data registers, the stage-1 direction register and o1..o4 to 0.
  - Release is synchronous to the next clk edge.
- Stage 1 (registered on clk when en=1):
  - CAS(in1,in3) -> s1,s3; CAS(in2,in4) -> s2,s4.
  - direction is registered alongside as dir_s1.
- Stage 2 (registered on clk when en=1, uses dir_s1):
  - CAS(s1,s2) -> o1,o2; CAS(s3,s4) -> o3,o4.
- CAS(a,b) definition:
  - dir=1: lo=min(a,b) to the first output, hi=max(a,b) to the second.
  - dir=0: reversed.
- Equal operands: output both unchanged (no swap); results are identical either way.
- Latency:
  - 2 enabled clock edges from inputs to o1..o4.
  - Throughput is one sample per enabled cycle.
  - direction travels with its data, so direction changes never corrupt an in-flight sample.
- en=0: both stages hold their contents; outputs are stable; inputs are ignored.
- Reset mid-operation: in-flight data is discarded; outputs read 0 until two enabled cycles after release with valid inputs.
- Non-bitonic input: the network is still applied; the output is deterministic but not guaranteed sorted. This is not an error condition.
- Comparison:
  - Full DATA_WIDTH, unsigned by default.
  - No arithmetic, so no overflow concerns.

Optional Feature:
- Macro BM4_SIGNED_EN.
- Defined: all CAS comparisons treat elements as two's-complement signed (e.g. 32'hFFFF_FFFF = -1 sorts below 0).
- Undefined: unsigned compare (32'hFFFF_FFFF is the maximum).
- Port list and latency are identical in both builds.

Decomposition:
- Shared package bm_pkg:
  - direction constants DIR_ASC=1'b1, DIR_DESC=1'b0.
  - Default width constant BM_DATA_WIDTH=32.
- One natural sub-module, bm_cas: combinational compare-and-swap with inputs a, b, dir and outputs first, second.
  - Parameterised by DATA_WIDTH.
  - Honours BM4_SIGNED_EN.
- bitonic_merge4 instantiates 4 bm_cas plus the two register stages.

Test Plan:
1. Reset: hold rst=0 with en=1 and arbitrary inputs -> o1..o4 = 0 throughout; assert rst low mid-stream -> outputs clear immediately, without waiting for a clock edge.
2. Ascending sort: rst=1, en=1, direction=1, in1..in4 = 6,5,4,3 -> after 2 edges o1..o4 = 3,4,5,6.
3. Descending sort: direction=0, inputs 1,4,7,2 (bitonic) -> after 2 edges o1..o4 = 7,4,2,1.
4. Pipelining with direction change: present {6,5,4,3} dir=1, then {1,4,7,2} dir=0 on consecutive cycles -> outputs 3,4,5,6 then 7,4,2,1 on consecutive cycles.
5. Enable stall: load {6,5,4,3} dir=1, drop en for 5 cycles while changing inputs to {9,9,9,9} -> outputs frozen; after en returns, 3,4,5,6 emerges as if the stall never happened.
6. Edge values: inputs 32'hFFFF_FFFF,5,5,0 with dir=1 -> o1..o4 = 0,5,5,FFFF_FFFF unsigned; with BM4_SIGNED_EN -> FFFF_FFFF,0,5,5.
